// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO pop side, the output stream and the flush/status signals.
// master = the adapter itself; slave = whatever surrounds it.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             fifoEmpty;
  logic [WIDTH-1:0] fifoData;
  logic             fifoRdEn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic             flush;
  logic             flushDone;
  logic [15:0]      wordCount;

  modport master (
    input  fifoEmpty, fifoData, outReady, flush,
    output fifoRdEn, outValid, outData, flushDone, wordCount
  );

  modport slave (
    output fifoEmpty, fifoData, outReady, flush,
    input  fifoRdEn, outValid, outData, flushDone, wordCount
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO pop interface -> valid/ready stream adapter with a 3-entry skid buffer and flush.
// Define FIFO_RD_CNT_EN to build the accepted-word counter; otherwise wordCount is tied to 0.
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  fifo_rd_stream_if.master   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [3];
  logic [1:0]       rdPtr;
  logic [1:0]       wrPtr;
  logic [1:0]       cnt;
  logic             inFlight;
  logic             popEn;
  logic             handshake;

  function automatic logic [1:0] nextPtr(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Pops depend only on registered state and fifoEmpty, never on outReady.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    popEn = 1'b0;
    if (!rst && !bus.fifoEmpty) begin
      case (state)
        RUN:     popEn = ({1'b0, cnt} + {2'b00, inFlight}) < 3'd3;
        FLUSH:   popEn = 1'b1;
        default: popEn = 1'b0;
      endcase
    end
  end

  assign bus.fifoRdEn  = popEn;
  assign bus.outValid  = (cnt != 2'd0) && (state == RUN);
  assign bus.outData   = mem[rdPtr];
  assign bus.flushDone = (state == DONE);
  assign handshake     = bus.outValid && bus.outReady;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      rdPtr    <= 2'd0;
      wrPtr    <= 2'd0;
      cnt      <= 2'd0;
      inFlight <= 1'b0;
      // NOTE: the buffer is reset too because outData must read 0 out of reset; it is only 3 words.
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inFlight <= popEn;
      case (state)
        RUN: begin
          if (bus.flush) begin
            state <= FLUSH;
            rdPtr <= 2'd0;
            wrPtr <= 2'd0;
            cnt   <= 2'd0;
          end else begin
            if (inFlight) begin
              mem[wrPtr] <= bus.fifoData;
              wrPtr      <= nextPtr(wrPtr);
            end
            if (handshake) rdPtr <= nextPtr(rdPtr);
            case ({inFlight, handshake})
              2'b10:   cnt <= cnt + 2'd1;
              2'b01:   cnt <= cnt - 2'd1;
              default: cnt <= cnt;
            endcase
          end
        end
        // Returning words are dropped; leave once nothing is queued or in flight.
        FLUSH:   if (bus.fifoEmpty && !inFlight) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [15:0] wordCountQ;

  always_ff @(posedge clk) begin
    if (rst)                            wordCountQ <= 16'd0;
    else if (state == RUN && bus.flush) wordCountQ <= 16'd0;
    else if (handshake)                 wordCountQ <= wordCountQ + 16'd1;
  end

  assign bus.wordCount = wordCountQ;
`else
  assign bus.wordCount = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a small FIFO model feeds the adapter, vectors check the stream.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrEn = 1'b0;
  logic [7:0] wrData = 8'h00;
  int         vectors = 0;
  int         miscompares = 0;

  fifo_rd_stream_if #(.WIDTH(8)) bus ();

  fifo_rd_stream #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Upstream synchronous FIFO model: depth 8, registered dataOut one cycle after a pop.
  logic [7:0] fMem [8];
  logic [2:0] fWp = '0;
  logic [2:0] fRp = '0;
  logic [3:0] fCount = '0;
  logic [7:0] fOut = '0;
  int         popCount = 0;
  logic       fWr;
  logic       fRd;

  assign fWr           = wrEn && (fCount != 4'd8);
  assign fRd           = bus.fifoRdEn && (fCount != 4'd0);
  assign bus.fifoEmpty = (fCount == 4'd0);
  assign bus.fifoData  = fOut;

  always @(posedge clk) begin
    if (fWr) begin
      fMem[fWp] <= wrData;
      fWp       <= fWp + 3'd1;
    end
    if (fRd) begin
      fOut     <= fMem[fRp];
      fRp      <= fRp + 3'd1;
      popCount <= popCount + 1;
    end
    fCount <= fCount + {3'b000, fWr} - {3'b000, fRd};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cntExp(input logic [15:0] v);
    return CNT_EN ? v : 16'd0;
  endfunction

  initial begin
    bit   expValid [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   got;
    int   first;
    int   last;
    int   maxCnt;
    int   pops0;
    int   pulses;
    bit   sawValid;
    bit   found;
    int   orderErr;
    int   written;
    logic [7:0] seen;

    bus.outReady = 1'b0;
    bus.flush    = 1'b0;

    // ---- reset state, with 4 words preloaded while in reset
    tick();
    tick();
    check("rst_rden",   bus.fifoRdEn,  0);
    check("rst_valid",  bus.outValid,  0);
    check("rst_data",   bus.outData,   0);
    check("rst_done",   bus.flushDone, 0);
    check("rst_wcount", bus.wordCount, 0);
    for (int i = 0; i < 4; i++) begin
      wrEn   = 1'b1;
      wrData = 8'h11 + 8'(i);
      tick();
    end
    wrEn = 1'b0;
    check("rst_rden_held", bus.fifoRdEn, 0);
    rst          = 1'b0;
    bus.outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_valid%0d", i), bus.outValid, expValid[i]);
      if (expValid[i]) check($sformatf("t1_data%0d", i), bus.outData, 8'h10 + 8'(i));
    end
    check("t1_wcount", bus.wordCount, cntExp(16'd4));

    // ---- continuous writes 0..11, full throughput
    got = 0; first = -1; last = -1; maxCnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.outValid) begin
        check($sformatf("t2_data%0d", got), bus.outData, got);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (int'(dut.cnt) > maxCnt) maxCnt = int'(dut.cnt);
      wrEn   = (c < 12);
      wrData = 8'(c);
      tick();
    end
    wrEn = 1'b0;
    check("t2_count",  got, 12);
    check("t2_span",   last - first, 11);
    check("t2_maxcnt", maxCnt <= 2, 1);

    // ---- stall: outReady low while 8 words arrive
    bus.outReady = 1'b0;
    pops0 = popCount;
    for (int i = 0; i < 8; i++) begin
      wrEn   = 1'b1;
      wrData = 8'h30 + 8'(i);
      tick();
    end
    wrEn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t3_pops",  popCount - pops0, 3);
    check("t3_cnt",   dut.cnt, 3);
    check("t3_valid", bus.outValid, 1);
    check("t3_hold",  bus.outData, 8'h30);
    bus.outReady = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.outValid) begin
        check($sformatf("t3_data%0d", got), bus.outData, 8'h30 + got);
        got++;
      end
      tick();
    end
    check("t3_count", got, 8);

    // ---- flush with FIFO and buffer full
    bus.outReady = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wrEn   = 1'b1;
      wrData = 8'h40 + 8'(i);
      tick();
    end
    wrEn = 1'b0;
    tick();
    check("t4_fifo_full", fCount, 8);
    check("t4_buf_full",  dut.cnt, 3);
    pops0     = popCount;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t4_valid_drop", bus.outValid, 0);
    pulses = 0; sawValid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.flushDone) pulses++;
      if (bus.outValid) sawValid = 1'b1;
      tick();
    end
    check("t4_pulses",   pulses, 1);
    check("t4_no_out",   sawValid, 0);
    check("t4_drained",  fCount, 0);
    check("t4_pops",     popCount - pops0, 8);
    check("t4_wcount",   bus.wordCount, 0);
    bus.outReady = 1'b1;
    wrEn   = 1'b1;
    wrData = 8'hA5;
    tick();
    wrEn  = 1'b0;
    found = 1'b0;
    seen  = 8'h00;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.outValid) begin
        found = 1'b1;
        seen  = bus.outData;
      end
      tick();
    end
    check("t4_after_found", found, 1);
    check("t4_after_data",  seen, 8'hA5);

    // ---- reset one cycle after a pop
    for (int i = 0; i < 4; i++) tick();
    wrEn   = 1'b1;
    wrData = 8'h77;
    tick();
    wrEn = 1'b0;
    check("t5_rden", bus.fifoRdEn, 1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_rden_rst", bus.fifoRdEn,  0);
    check("t5_valid",    bus.outValid,  0);
    check("t5_data",     bus.outData,   0);
    check("t5_done",     bus.flushDone, 0);
    check("t5_wcount",   bus.wordCount, 0);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.outValid) sawValid = 1'b1;
    end
    check("t5_no_ghost", sawValid, 0);
    wrEn   = 1'b1;
    wrData = 8'h78;
    tick();
    wrEn  = 1'b0;
    found = 1'b0;
    seen  = 8'h00;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.outValid) begin
        found = 1'b1;
        seen  = bus.outData;
      end
      tick();
    end
    check("t5_next_data", seen, 8'h78);

    // ---- 70000 handshakes, counter wrap, then flush clears it
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = 0; written = 0; orderErr = 0;
    for (int c = 0; c < 75000 && got < 70000; c++) begin
      if (bus.outValid) begin
        if (bus.outData !== 8'(got)) orderErr++;
        got++;
      end
      wrEn   = (written < 70000);
      wrData = 8'(written);
      if (written < 70000) written++;
      tick();
    end
    wrEn = 1'b0;
    tick();
    tick();
    check("t6_handshakes", got, 70000);
    check("t6_order_err",  orderErr, 0);
    check("t6_wcount",     bus.wordCount, cntExp(16'd4464));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("t6_wcount_flush", bus.wordCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
